sdram_frame_sequencer: RTL and testbench
========================================

# sdram_frame_sequencer

Frame-level sequencer that sits upstream of, and wraps, the two interleaved-bank SDRAM controllers (bank 0, bank 1). It generates the shared 8-cycle `cycle` count and the per-frame `en` gate. It runs the SDRAM power-up/mode-register init sequence and inserts periodic auto-refresh frames. It muxes the two bank controllers' command/address/data outputs onto the single SDRAM pin bus.

## Interface
- `INIT_WAIT`, 20000: clk cycles of NOP after reset before the init commands (≥200 µs at the clk frequency).
- `REFRESH_INTERVAL`, 780: clk cycles between refresh requests; must be ≥16.
- `MODE_REG`, 13'h020: value driven on `sd_a` with LOAD_MODE (CAS latency 2, burst length 1, sequential).

Ports:
- `clk` input 1: the single clock.
- `rst` input 1: reset; asynchronous and active-high.
- `cycle` output 3: frame position 0..7, broadcast to both bank controllers.
- `en` output 1: bank-controller enable; constant across each window of cycles 7,0..6.
- `ready` output 1: init complete.
- `refresh_frame` output 1: high while the current window is a refresh window (en low in RUN).
- `b0_cmd` / `b1_cmd` input 3: bank controller command.
- `b0_a` / `b1_a` input 13: bank controller address.
- `b0_dqm` / `b1_dqm` input 2: bank controller byte mask.
- `b0_dout` / `b1_dout` input 16: bank controller write data.
- `b0_dout_en` / `b1_dout_en` input 1: bank controller write-data enable.
- `sd_cke` output 1: SDRAM clock enable.
- `sd_cmd` output 3: SDRAM command pins.
- `sd_a` output 13: SDRAM address pins.
- `sd_ba` output 2: SDRAM bank-address pins.
- `sd_dqm` output 2: SDRAM byte-mask pins.
- `sd_data_out` output 16: SDRAM write data.
- `sd_data_out_en` output 1: SDRAM write-data output enable.

## Operation
- Command encoding `{RAS,CAS,WE}`: LOAD_MODE 000, REFRESH 001, PRECHARGE 010, ACTIVATE 011, WRITE 100, READ 101, NOP 111.
- `cycle`: free-running 3-bit counter from reset release, wraps 7→0; never stalls.
- Init FSM states:
  - `S_WAIT`: count `INIT_WAIT` cycles.
  - `S_PRE`, `S_REF1`, `S_REF2`, `S_MRS`: each issues its command at cycle 0 of successive frames. PRECHARGE uses `sd_a[10]`=1 (all banks). `S_MRS` drives `sd_a`=`MODE_REG`, `sd_ba`=0.
  - `S_GAP`: one NOP frame.
  - `S_RUN`: normal operation.
  - Leaving `S_WAIT` waits for the next cycle 0.
- `ready` rises at the 6→7 edge that ends `S_GAP`. `en` rises at that same edge.
- Refresh timer:
  - Counts only in `S_RUN`. At terminal count it sets `refresh_pending` and restarts.
  - At each 6→7 edge in `S_RUN`: `en <= ~refresh_pending`; `refresh_frame <= refresh_pending`.
  - In a refresh window: REFRESH on cycle 0, NOP elsewhere. `refresh_pending` clears at cycle 0 of that window.
  - A timer expiry in the same cycle as the clear re-sets pending; set wins.
- Pin mux:
  - When `en`=1: bank `cycle[0]`'s signals drive `sd_cmd`/`sd_a`/`sd_dqm`/`sd_data_out`/`sd_data_out_en`, and `sd_ba`={1'b0,`cycle[0]`}.
  - When `en`=0: sequencer-owned command, `sd_dqm`=11, `sd_data_out_en`=0, `sd_data_out`=0.
- The mux is combinational. Registering it would shift commands by one cycle and break the CAS-2 capture at cycles 4/5.

## Timing
- Reset values: `cycle`=0, `en`=0, `ready`=0, `refresh_frame`=0, `sd_cke`=0, `sd_cmd`=NOP, `sd_a`=0, `sd_ba`=0, `sd_dqm`=11, `sd_data_out_en`=0. Timer cleared, pending cleared, FSM=`S_WAIT`.
- `sd_cke` goes to 1 on the first clk after reset release.
- Reset asserted mid-init or mid-refresh: everything returns to reset values immediately and init restarts from `S_WAIT`.
- Refresh window spacing: REFRESH at cycle 0 follows the prior frame's last auto-precharge by ≥4 cycles. The next ACTIVATE follows REFRESH by 8 cycles.
- Worst-case refresh latency from timer expiry to REFRESH command: 16 cycles.

## Structure
- Shared package `sdram_pkg`: command localparams and the init/run state enum. The bank controllers use the same command constants.
- One natural sub-module: `sdram_refresh_timer` (counter, pending flag, clear input).

## Test plan
- `INIT_WAIT`=16, `REFRESH_INTERVAL`=40: after reset, 16 NOP cycles, then PRECHARGE (`sd_a[10]`=1), REFRESH, REFRESH, LOAD_MODE (`sd_a`=020) each at cycle 0 of consecutive frames. `ready`/`en` rise at the 6→7 edge after the following NOP frame.
- In RUN with `en`=1, `b0_cmd`=011/`b0_a`=0x123 and `b1_cmd`=101/`b1_a`=0x456: even cycles show 011/0x123/`ba`=0, odd cycles show 101/0x456/`ba`=1.
- Refresh insertion: within 16 cycles of timer expiry, `en` and `refresh_frame` change only at a 6→7 edge. REFRESH appears at cycle 0, `sd_data_out_en`=0 and `sd_dqm`=11 throughout the window, and `en` returns to 1 at the next 6→7 edge.
- Bank controllers driving WRITE (`b0_dout_en`=1) during a refresh window: pins stay NOP and `sd_data_out_en` stays 0.
- Reset asserted during `S_REF1`: outputs hit reset values asynchronously. After release, the full init sequence restarts with `INIT_WAIT` counted from zero.
- Run 10 refresh intervals: REFRESH count equals 10 ±1, and no two REFRESH commands are less than 8 cycles apart.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared SDRAM command encodings and sequencer state type.
// The bank controllers decode and drive these same {RAS,CAS,WE} constants.
package sdram_pkg;

    localparam logic [2:0] CMD_LOAD_MODE = 3'b000;
    localparam logic [2:0] CMD_REFRESH   = 3'b001;
    localparam logic [2:0] CMD_PRECHARGE = 3'b010;
    localparam logic [2:0] CMD_ACTIVATE  = 3'b011;
    localparam logic [2:0] CMD_WRITE     = 3'b100;
    localparam logic [2:0] CMD_READ      = 3'b101;
    localparam logic [2:0] CMD_NOP       = 3'b111;

    // A10 high selects all banks for PRECHARGE.
    localparam logic [12:0] PRECHARGE_ALL_A = 13'h0400;

    typedef enum logic [2:0] {
        S_WAIT = 3'd0,
        S_PRE  = 3'd1,
        S_REF1 = 3'd2,
        S_REF2 = 3'd3,
        S_MRS  = 3'd4,
        S_GAP  = 3'd5,
        S_RUN  = 3'd6
    } seq_state_t;

endpackage

// File: rtl/sdram_refresh_timer.sv
// Periodic refresh request generator. Counts only while run is high and
// raises pending at terminal count; clear drops it unless a new expiry
// lands in the same cycle, in which case the new request is kept.
module sdram_refresh_timer #(
    parameter int INTERVAL = 780
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clear,
    output logic pending
);

    localparam int CNT_W = $clog2(INTERVAL);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INTERVAL - 1);

    logic [CNT_W-1:0] cnt_r;
    logic             pending_r;

    // Interval counter and sticky pending flag (expiry takes priority over clear).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r     <= '0;
            pending_r <= 1'b0;
        end else if (!run) begin
            cnt_r     <= '0;
            pending_r <= 1'b0;
        end else if (cnt_r == CNT_LAST) begin
            cnt_r     <= '0;
            pending_r <= 1'b1;
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
            if (clear) begin
                pending_r <= 1'b0;
            end
        end
    end

    assign pending = pending_r;

endmodule

// File: rtl/sdram_frame_sequencer.sv
// Frame sequencer for two interleaved SDRAM bank controllers: free-running
// 8-cycle frame counter, power-up init sequence, periodic refresh windows
// and the combinational pin mux between bank 0, bank 1 and the sequencer.
module sdram_frame_sequencer
    import sdram_pkg::*;
#(
    parameter int          INIT_WAIT        = 20000,
    parameter int          REFRESH_INTERVAL = 780,
    parameter logic [12:0] MODE_REG         = 13'h020
) (
    input  logic        clk,
    input  logic        rst,
    output logic [2:0]  cycle,
    output logic        en,
    output logic        ready,
    output logic        refresh_frame,
    input  logic [2:0]  b0_cmd,
    input  logic [12:0] b0_a,
    input  logic [1:0]  b0_dqm,
    input  logic [15:0] b0_dout,
    input  logic        b0_dout_en,
    input  logic [2:0]  b1_cmd,
    input  logic [12:0] b1_a,
    input  logic [1:0]  b1_dqm,
    input  logic [15:0] b1_dout,
    input  logic        b1_dout_en,
    output logic        sd_cke,
    output logic [2:0]  sd_cmd,
    output logic [12:0] sd_a,
    output logic [1:0]  sd_ba,
    output logic [1:0]  sd_dqm,
    output logic [15:0] sd_data_out,
    output logic        sd_data_out_en
);

    localparam int WAIT_W = $clog2(INIT_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(INIT_WAIT - 1);

    seq_state_t        state_r;
    logic [2:0]        cycle_r;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic              en_r;
    logic              ready_r;
    logic              refresh_frame_r;
    logic              cke_r;

    logic              wait_done_s;
    logic              run_s;
    logic              refresh_clear_s;
    logic              refresh_pending_s;
    logic [2:0]        seq_cmd_s;
    logic [12:0]       seq_a_s;

    assign wait_done_s     = (wait_cnt_r == WAIT_LAST);
    assign run_s           = (state_r == S_RUN);
    // The pending request is consumed when its window issues REFRESH.
    assign refresh_clear_s = run_s && refresh_frame_r && (cycle_r == 3'd0);

    sdram_refresh_timer #(
        .INTERVAL (REFRESH_INTERVAL)
    ) u_refresh_timer (
        .clk     (clk),
        .rst     (rst),
        .run     (run_s),
        .clear   (refresh_clear_s),
        .pending (refresh_pending_s)
    );

    // Frame counter, init/run FSM and the window-aligned en/ready/refresh_frame registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r         <= S_WAIT;
            cycle_r         <= 3'd0;
            wait_cnt_r      <= '0;
            en_r            <= 1'b0;
            ready_r         <= 1'b0;
            refresh_frame_r <= 1'b0;
            cke_r           <= 1'b0;
        end else begin
            cycle_r <= cycle_r + 3'd1;
            cke_r   <= 1'b1;
            case (state_r)
                S_WAIT: begin
                    if (!wait_done_s) begin
                        wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
                    end
                    // Init commands always start on a frame boundary.
                    if (wait_done_s && (cycle_r == 3'd7)) begin
                        state_r <= S_PRE;
                    end
                end
                S_PRE: begin
                    if (cycle_r == 3'd7) begin
                        state_r <= S_REF1;
                    end
                end
                S_REF1: begin
                    if (cycle_r == 3'd7) begin
                        state_r <= S_REF2;
                    end
                end
                S_REF2: begin
                    if (cycle_r == 3'd7) begin
                        state_r <= S_MRS;
                    end
                end
                S_MRS: begin
                    if (cycle_r == 3'd7) begin
                        state_r <= S_GAP;
                    end
                end
                S_GAP: begin
                    // Bank windows run 7,0..6, so hand-over happens at the 6->7 edge.
                    if (cycle_r == 3'd6) begin
                        state_r         <= S_RUN;
                        en_r            <= 1'b1;
                        ready_r         <= 1'b1;
                        refresh_frame_r <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (cycle_r == 3'd6) begin
                        en_r            <= ~refresh_pending_s;
                        refresh_frame_r <= refresh_pending_s;
                    end
                end
                default: begin
                    state_r <= S_WAIT;
                end
            endcase
        end
    end

    // Sequencer-owned command: init commands and REFRESH only ever issue at cycle 0.
    always_comb begin
        seq_cmd_s = CMD_NOP;
        seq_a_s   = 13'd0;
        if (cycle_r == 3'd0) begin
            case (state_r)
                S_PRE: begin
                    seq_cmd_s = CMD_PRECHARGE;
                    seq_a_s   = PRECHARGE_ALL_A;
                end
                S_REF1, S_REF2: begin
                    seq_cmd_s = CMD_REFRESH;
                end
                S_MRS: begin
                    seq_cmd_s = CMD_LOAD_MODE;
                    seq_a_s   = MODE_REG;
                end
                S_RUN: begin
                    if (refresh_frame_r) begin
                        seq_cmd_s = CMD_REFRESH;
                    end else begin
                        seq_cmd_s = CMD_NOP;
                    end
                end
                default: begin
                    seq_cmd_s = CMD_NOP;
                end
            endcase
        end else begin
            seq_cmd_s = CMD_NOP;
        end
    end

    // Pin mux; kept combinational so bank commands land on the cycle the controllers expect.
    always_comb begin
        sd_cmd         = seq_cmd_s;
        sd_a           = seq_a_s;
        sd_ba          = 2'b00;
        sd_dqm         = 2'b11;
        sd_data_out    = 16'h0000;
        sd_data_out_en = 1'b0;
        if (en_r) begin
            sd_ba = {1'b0, cycle_r[0]};
            if (cycle_r[0]) begin
                sd_cmd         = b1_cmd;
                sd_a           = b1_a;
                sd_dqm         = b1_dqm;
                sd_data_out    = b1_dout;
                sd_data_out_en = b1_dout_en;
            end else begin
                sd_cmd         = b0_cmd;
                sd_a           = b0_a;
                sd_dqm         = b0_dqm;
                sd_data_out    = b0_dout;
                sd_data_out_en = b0_dout_en;
            end
        end else begin
            sd_ba = 2'b00;
        end
    end

    assign cycle         = cycle_r;
    assign en            = en_r;
    assign ready         = ready_r;
    assign refresh_frame = refresh_frame_r;
    assign sd_cke        = cke_r;

endmodule

// File: tb/tb_sdram_frame_sequencer.sv
// Directed bench for sdram_frame_sequencer with INIT_WAIT=16, REFRESH_INTERVAL=40.
// Index k means the k-th negedge after reset release (index 0 = release point).
module tb_sdram_frame_sequencer;
    import sdram_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  cycle;
    logic        en, ready, refresh_frame;
    logic [2:0]  b0_cmd, b1_cmd;
    logic [12:0] b0_a, b1_a;
    logic [1:0]  b0_dqm, b1_dqm;
    logic [15:0] b0_dout, b1_dout;
    logic        b0_dout_en, b1_dout_en;
    logic        sd_cke;
    logic [2:0]  sd_cmd;
    logic [12:0] sd_a;
    logic [1:0]  sd_ba, sd_dqm;
    logic [15:0] sd_data_out;
    logic        sd_data_out_en;

    int idx;
    int checks = 0;
    int errors = 0;

    sdram_frame_sequencer #(
        .INIT_WAIT        (16),
        .REFRESH_INTERVAL (40),
        .MODE_REG         (13'h020)
    ) dut (
        .clk(clk), .rst(rst), .cycle(cycle), .en(en), .ready(ready),
        .refresh_frame(refresh_frame),
        .b0_cmd(b0_cmd), .b0_a(b0_a), .b0_dqm(b0_dqm), .b0_dout(b0_dout), .b0_dout_en(b0_dout_en),
        .b1_cmd(b1_cmd), .b1_a(b1_a), .b1_dqm(b1_dqm), .b1_dout(b1_dout), .b1_dout_en(b1_dout_en),
        .sd_cke(sd_cke), .sd_cmd(sd_cmd), .sd_a(sd_a), .sd_ba(sd_ba), .sd_dqm(sd_dqm),
        .sd_data_out(sd_data_out), .sd_data_out_en(sd_data_out_en)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [2:0]  cyc;
        logic        cke;
        logic [2:0]  cmd;
        logic [12:0] a;
        logic [1:0]  ba;
        logic [1:0]  dqm;
        logic [15:0] dout;
        logic        oe;
        logic        en;
        logic        rdy;
        logic        rf;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s idx=%0d got=%0h want=%0h", name, idx, act, exp);
        end
    endtask

    // Sequencer-owned pins: dqm masked, no write data.
    function automatic vec_t seqv(input int i, input logic [2:0] cmd, input logic [12:0] a,
                                  input logic rdy, input logic rf);
        vec_t v;
        v.idx = i; v.cyc = 3'(i % 8); v.cke = (i != 0); v.cmd = cmd; v.a = a;
        v.ba = 2'b00; v.dqm = 2'b11; v.dout = 16'h0000; v.oe = 1'b0;
        v.en = 1'b0; v.rdy = rdy; v.rf = rf;
        return v;
    endfunction

    // Bank-owned pins: even cycles bank 0, odd cycles bank 1 (constant bank inputs below).
    function automatic vec_t bankv(input int i);
        vec_t v;
        v.idx = i; v.cyc = 3'(i % 8); v.cke = 1'b1; v.en = 1'b1; v.rdy = 1'b1; v.rf = 1'b0;
        if ((i % 2) == 1) begin
            v.cmd = 3'b101; v.a = 13'h456; v.ba = 2'b01; v.dqm = 2'b10; v.dout = 16'h5555; v.oe = 1'b0;
        end else begin
            v.cmd = 3'b011; v.a = 13'h123; v.ba = 2'b00; v.dqm = 2'b01; v.dout = 16'hAAAA; v.oe = 1'b1;
        end
        return v;
    endfunction

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        idx = 0;
    endtask

    task automatic advance_to(input int k);
        while (idx < k) begin
            @(negedge clk);
            #1;
            idx++;
        end
    endtask

    task automatic run_table(input int max_idx);
        foreach (vecs[n]) begin
            if (vecs[n].idx <= max_idx) begin
                advance_to(vecs[n].idx);
                chk("cycle", cycle, vecs[n].cyc);
                chk("cke", sd_cke, vecs[n].cke);
                chk("cmd", sd_cmd, vecs[n].cmd);
                chk("addr", sd_a, vecs[n].a);
                chk("ba", sd_ba, vecs[n].ba);
                chk("dqm", sd_dqm, vecs[n].dqm);
                chk("dout", sd_data_out, vecs[n].dout);
                chk("dout_en", sd_data_out_en, vecs[n].oe);
                chk("en", en, vecs[n].en);
                chk("ready", ready, vecs[n].rdy);
                chk("refresh_frame", refresh_frame, vecs[n].rf);
            end
        end
    endtask

    task automatic set_banks(input logic [2:0] c0);
        b0_cmd = c0;     b0_a = 13'h123; b0_dqm = 2'b01; b0_dout = 16'hAAAA; b0_dout_en = 1'b1;
        b1_cmd = 3'b101; b1_a = 13'h456; b1_dqm = 2'b10; b1_dout = 16'h5555; b1_dout_en = 1'b0;
    endtask

    initial begin
        int nref, last_ref, low_len;
        logic prev_en, prev_rf;

        set_banks(CMD_ACTIVATE);
        // Init: 16 NOP cycles, PRE/REF/REF/LMR at cycle 0 of frames 2..5, NOP frame, RUN at 55.
        vecs.push_back(seqv(0,  CMD_NOP,       13'h000, 1'b0, 1'b0));
        vecs.push_back(seqv(1,  CMD_NOP,       13'h000, 1'b0, 1'b0));
        vecs.push_back(seqv(15, CMD_NOP,       13'h000, 1'b0, 1'b0));
        vecs.push_back(seqv(16, CMD_PRECHARGE, 13'h400, 1'b0, 1'b0));
        vecs.push_back(seqv(17, CMD_NOP,       13'h000, 1'b0, 1'b0));
        vecs.push_back(seqv(24, CMD_REFRESH,   13'h000, 1'b0, 1'b0));
        vecs.push_back(seqv(25, CMD_NOP,       13'h000, 1'b0, 1'b0));
        vecs.push_back(seqv(32, CMD_REFRESH,   13'h000, 1'b0, 1'b0));
        vecs.push_back(seqv(40, CMD_LOAD_MODE, 13'h020, 1'b0, 1'b0));
        vecs.push_back(seqv(41, CMD_NOP,       13'h000, 1'b0, 1'b0));
        vecs.push_back(seqv(48, CMD_NOP,       13'h000, 1'b0, 1'b0));
        vecs.push_back(seqv(54, CMD_NOP,       13'h000, 1'b0, 1'b0));
        vecs.push_back(bankv(55));
        vecs.push_back(bankv(56));
        vecs.push_back(bankv(57));
        vecs.push_back(bankv(58));
        // Timer starts at 55, expires at the edge after 94; window 103..110, REFRESH at 104.
        vecs.push_back(bankv(94));
        vecs.push_back(bankv(102));
        vecs.push_back(seqv(103, CMD_NOP,     13'h000, 1'b1, 1'b1));
        vecs.push_back(seqv(104, CMD_REFRESH, 13'h000, 1'b1, 1'b1));
        vecs.push_back(seqv(105, CMD_NOP,     13'h000, 1'b1, 1'b1));
        vecs.push_back(seqv(110, CMD_NOP,     13'h000, 1'b1, 1'b1));
        vecs.push_back(bankv(111));

        release_reset();
        run_table(111);

        // Ten refresh intervals with bank 0 trying to WRITE throughout.
        set_banks(CMD_WRITE);
        prev_en = en; prev_rf = refresh_frame;
        nref = 0; last_ref = -100; low_len = 0;
        for (int k = 112; k < 512; k++) begin
            advance_to(k);
            if ((en !== prev_en) || (refresh_frame !== prev_rf)) chk("window_edge_cycle", cycle, 3'd7);
            chk("en_vs_refresh_frame", en, !refresh_frame);
            if (!en) begin
                low_len++;
                chk("win_dqm", sd_dqm, 2'b11);
                chk("win_dout_en", sd_data_out_en, 1'b0);
                chk("win_dout", sd_data_out, 16'h0000);
                chk("win_cmd", sd_cmd, (cycle == 3'd0) ? CMD_REFRESH : CMD_NOP);
            end
            if (en && !prev_en) begin
                chk("window_len", low_len, 8);
                low_len = 0;
            end
            if (sd_cmd == CMD_REFRESH) begin
                if (nref > 0) chk("refresh_gap_ge8", ((k - last_ref) >= 8), 1'b1);
                nref++;
                last_ref = k;
            end
            prev_en = en;
            prev_rf = refresh_frame;
        end
        chk("refresh_count_10pm1", ((nref >= 9) && (nref <= 11)), 1'b1);

        // Reset asserted while in S_REF1: outputs return to reset values without a clock edge.
        set_banks(CMD_ACTIVATE);
        release_reset();
        advance_to(24);
        chk("ref1_cmd", sd_cmd, CMD_REFRESH);
        advance_to(26);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_cycle", cycle, 3'd0);
        chk("rst_en", en, 1'b0);
        chk("rst_ready", ready, 1'b0);
        chk("rst_rf", refresh_frame, 1'b0);
        chk("rst_cke", sd_cke, 1'b0);
        chk("rst_cmd", sd_cmd, CMD_NOP);
        chk("rst_a", sd_a, 13'h000);
        chk("rst_ba", sd_ba, 2'b00);
        chk("rst_dqm", sd_dqm, 2'b11);
        chk("rst_dout_en", sd_data_out_en, 1'b0);

        // Full init must restart with the wait counted from zero.
        release_reset();
        run_table(58);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
